// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlap control,
// a registered match pulse and a saturating match counter.
module seq_detector_param #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               datain,
    input  logic               din_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               armed,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);

    typedef enum logic {S_UNCFG, S_RUN} state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               lenOk;
    logic               accept;
    logic               hit;
    logic [MAX_LEN-1:0] histNext;
    logic [LEN_W-1:0]   fillNext;
    logic [MAX_LEN-1:0] lenMask;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_UNCFG;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Match is judged on the post-shift history so the pulse lands one edge after the last bit.
    always_comb begin
        lenOk    = (cfg_len != '0) && (cfg_len <= LEN_MAX);
        accept   = (state_q == S_RUN) && din_valid && !cfg_load;
        histNext = {hist_q[MAX_LEN-2:0], datain};
        fillNext = (fill_q == LEN_MAX) ? fill_q : fill_q + 1'b1;
        lenMask  = ~({MAX_LEN{1'b1}} << len_q);
        hit      = accept && (fillNext >= len_q)
                   && (((histNext ^ pat_q) & lenMask) == '0);

        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = hit;
        err_d   = 1'b0;
        cnt_d   = cnt_q;

        if (cfg_load) begin
            if (lenOk) begin
                state_d = S_RUN;
                pat_d   = cfg_pattern;
                len_d   = cfg_len;
                ovl_d   = cfg_overlap;
                hist_d  = '0;
                fill_d  = '0;
            end else begin
                err_d = 1'b1;
            end
        end else if (accept) begin
            hist_d = histNext;
            fill_d = (hit && !ovl_q) ? '0 : fillNext;
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign armed     = (state_q == S_RUN);
    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: a default instance plus a CNT_W=2
// instance sharing the same stimulus to exercise counter saturation.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk;
    logic               rst_n;
    logic               datain;
    logic               din_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;

    logic               armedA, matchA, errA;
    logic [7:0]         cntA;
    logic               armedB, matchB, errB;
    logic [1:0]         cntB;

    int totalCount = 0;
    int badCount   = 0;

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dutA (
        .clk(clk), .rst_n(rst_n), .datain(datain), .din_valid(din_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .armed(armedA), .match(matchA), .match_cnt(cntA), .cfg_err(errA)
    );

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dutB (
        .clk(clk), .rst_n(rst_n), .datain(datain), .din_valid(din_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .armed(armedB), .match(matchB), .match_cnt(cntB), .cfg_err(errB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalCount++;
        if (observed !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One cycle with the given data bit and valid; outputs then reflect that edge.
    task automatic applyStimulus(input logic bitIn, input logic valid);
        datain    = bitIn;
        din_valid = valid;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic loadConfig(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                              input logic ovl);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cfg_load    = 1'b1;
        tick();
        cfg_load    = 1'b0;
        din_valid   = 1'b0;
    endtask

    task automatic sendBits(input string tag, input logic [MAX_LEN-1:0] bits,
                            input int n, input logic [MAX_LEN-1:0] expMatch);
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(bits[i], 1'b1);
            checkOutput($sformatf("%s_m%0d", tag, n - 1 - i), matchA, expMatch[i]);
        end
    endtask

    initial begin
        rst_n = 1'b0; datain = 1'b0; din_valid = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
        tick();
        tick();
        checkOutput("rst_armed", armedA, 0);
        checkOutput("rst_match", matchA, 0);
        checkOutput("rst_cnt", cntA, 0);
        checkOutput("rst_err", errA, 0);
        rst_n = 1'b1;

        // Illegal length from reset leaves the block unconfigured
        loadConfig(8'h01, 4'd0, 1'b0);
        checkOutput("uncfg_err", errA, 1);
        checkOutput("uncfg_armed", armedA, 0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("uncfg_match", matchA, 0);
        checkOutput("uncfg_errdrop", errA, 0);

        // 10011, len 5, non-overlapping
        loadConfig(8'b10011, 4'd5, 1'b0);
        checkOutput("p5_armed", armedA, 1);
        checkOutput("p5_err", errA, 0);
        sendBits("p5", 8'b10011, 5, 8'b00001);
        checkOutput("p5_cnt", cntA, 1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("p5_pulse_end", matchA, 0);

        // 11 on 1111: overlapping then non-overlapping
        loadConfig(8'b11, 4'd2, 1'b1);
        sendBits("ov1", 8'b1111, 4, 8'b0111);
        checkOutput("ov1_cnt", cntA, 4);
        loadConfig(8'b11, 4'd2, 1'b0);
        sendBits("ov0", 8'b1111, 4, 8'b0101);
        checkOutput("ov0_cnt", cntA, 6);

        // 1001 with a valid gap in the middle
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        checkOutput("clr_cnt", cntA, 0);
        loadConfig(8'b1001, 4'd4, 1'b1);
        sendBits("gapA", 8'b10, 2, 8'b00);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("gap_idle", matchA, 0);
        sendBits("gapB", 8'b01, 2, 8'b01);
        checkOutput("gap_cnt", cntA, 1);

        // Final bit coincident with cfg_load is dropped and history cleared
        sendBits("drop", 8'b100, 3, 8'b000);
        datain = 1'b1;
        din_valid = 1'b1;
        loadConfig(8'b1001, 4'd4, 1'b1);
        checkOutput("drop_match", matchA, 0);
        sendBits("dropAfter", 8'b1, 1, 8'b0);
        checkOutput("drop_cnt", cntA, 1);

        // Illegal loads keep the running config
        loadConfig(8'hFF, 4'd0, 1'b0);
        checkOutput("bad0_err", errA, 1);
        checkOutput("bad0_armed", armedA, 1);
        loadConfig(8'hFF, 4'd9, 1'b0);
        checkOutput("bad9_err", errA, 1);
        sendBits("keep", 8'b001, 3, 8'b001);
        checkOutput("keep_cnt", cntA, 2);

        // len 1 and counter saturation on the 2-bit instance
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        loadConfig(8'b1, 4'd1, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput($sformatf("sat_m%0d", i), matchB, 1);
            checkOutput($sformatf("sat_cnt%0d", i), cntB, (i > 3) ? 3 : i);
        end
        checkOutput("sat_cntA", cntA, 6);
        applyStimulus(1'b0, 1'b1);
        checkOutput("len1_zero", matchA, 0);
        cnt_clr = 1'b1;
        applyStimulus(1'b1, 1'b1);
        cnt_clr = 1'b0;
        checkOutput("clrhit_match", matchA, 1);
        checkOutput("clrhit_cntA", cntA, 0);
        checkOutput("clrhit_cntB", cntB, 0);

        // Reset part way through a pattern
        loadConfig(8'b10011, 4'd5, 1'b0);
        sendBits("mid", 8'b100, 3, 8'b000);
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1);
        rst_n = 1'b1;
        checkOutput("mid_armed", armedA, 0);
        checkOutput("mid_match", matchA, 0);
        checkOutput("mid_cnt", cntA, 0);
        checkOutput("mid_err", errA, 0);
        sendBits("midRest", 8'b11, 2, 8'b00);
        checkOutput("midRest_cnt", cntA, 0);
        loadConfig(8'b10011, 4'd5, 1'b0);
        sendBits("reload", 8'b10011, 5, 8'b00001);
        checkOutput("reload_cnt", cntA, 1);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
